uart_tx_arbiter: RTL



---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The optional tag header (UART_ARB_TAG_EN) uses TAG_PREFIX and tag_byte().
package uart_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int TAG_IDX_W = $clog2(MAX_REQ);
    localparam logic [3:0] TAG_PREFIX = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } arb_state_e;

    function automatic logic [7:0] tag_byte(input logic [TAG_IDX_W-1:0] idx);
        return {TAG_PREFIX, idx};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after (last+1) mod N,
// wrapping with a compare against N so non-power-of-two N never yields idx >= N.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int               sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        sum_s  = 0;
        cand_s = '0;
        for (int k = N; k >= 1; k--) begin
            sum_s  = int'(last) + k;
            cand_s = (sum_s >= N) ? IDX_W'(sum_s - N) : IDX_W'(sum_s);
            any    = any | req[cand_s];
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter among N requesters.
// Define UART_ARB_TAG_EN to prefix every message with a {4'hA, grantee} header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_byte,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

`ifdef UART_ARB_TAG_EN
    localparam arb_state_e FIRST_ST = ST_HDR;
`else
    localparam arb_state_e FIRST_ST = ST_SEND;
`endif

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_byte_q, tx_byte_d;

    logic             free_s;
    logic             pick_any_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [N-1:0]     req_ready_s;
    logic [7:0]       sel_byte_s;
    logic             sel_valid_s;
    logic             sel_last_s;

    assign free_s = !tx_valid_q || tx_ready;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req  (req_valid),
        .last (last_q),
        .any  (pick_any_s),
        .idx  (pick_idx_s)
    );

    // Route the current grantee's byte, valid and last flag.
    always_comb begin
        sel_byte_s  = 8'h00;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            sel_byte_s  = (grant_q == IDX_W'(i)) ? req_byte[8*i +: 8] : sel_byte_s;
            sel_valid_s = (grant_q == IDX_W'(i)) ? req_valid[i]       : sel_valid_s;
            sel_last_s  = (grant_q == IDX_W'(i)) ? req_last[i]        : sel_last_s;
        end
    end

    // Next-state, grant bookkeeping and output-register load.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        tx_byte_d   = tx_byte_q;
        tx_valid_d  = tx_valid_q && !tx_ready;
        req_ready_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_d = pick_idx_s;
                    state_d = FIRST_ST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_HDR: begin
                if (free_s) begin
                    tx_byte_d  = tag_byte(TAG_IDX_W'(grant_q));
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    state_d = ST_HDR;
                end
            end
`endif
            ST_SEND: begin
                req_ready_s[grant_q] = free_s;
                if (free_s && sel_valid_s) begin
                    tx_byte_d  = sel_byte_s;
                    tx_valid_d = 1'b1;
                    if (sel_last_s) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    // A stalled grantee keeps the grant; messages never interleave.
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any partial message.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= IDX_W'(N - 1);
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign req_ready = req_ready_s;
    assign tx_byte   = tx_byte_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != ST_IDLE) || tx_valid_q;
    assign grant_idx = grant_q;

endmodule
